keypad_entry_unit: RTL and testbench

//  Parametrised keypad number-entry engine sitting between the keypad scanner and the CPU I/O path.

---
 rtl/keypad_entry_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_keypad_entry_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_unit.sv
// Keypad number-entry engine: debounces scanner coordinates, buffers digits, converts them to binary
// and hands the result to the CPU with a valid/ack handshake.

module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_coord,
  output logic       key_pulse,
  output logic [7:0] key_code
);
  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DB_TOP = DCW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]     prev_q;
  logic [DCW-1:0] cnt_q;
  logic           armed_q;
  logic           code_ok, restart, hit;

  assign code_ok = $onehot(key_coord[7:4]) && $onehot(key_coord[3:0]);
  // A change or an illegal multi-key code keeps the stability counter at zero.
  assign restart = (key_coord != prev_q) || (key_coord != 8'h00 && !code_ok);
  // Fires once, on the cycle the value has been seen DEBOUNCE_CYCLES times in a row.
  assign hit     = !restart && (cnt_q == DB_TOP - DCW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      key_pulse <= 1'b0;
      key_code  <= '0;
    end else begin
      prev_q    <= key_coord;
      key_pulse <= 1'b0;
      if (restart)             cnt_q <= '0;
      else if (cnt_q != DB_TOP) cnt_q <= cnt_q + DCW'(1);
      if (hit) begin
        if (armed_q && key_coord != 8'h00) begin
          key_pulse <= 1'b1;
          key_code  <= key_coord;
          armed_q   <= 1'b0;
        end else if (!armed_q && key_coord == 8'h00) begin
          armed_q <= 1'b1;
        end
      end
    end
  end
endmodule

module keypad_entry_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        key_coord,
  input  logic                              input_enable,
  input  logic                              hex_mode,
  input  logic                              enter_btn,
  input  logic                              clear_btn,
  input  logic                              data_ack,
  output logic                              cpu_pause,
  output logic                              data_valid,
  output logic [DATA_WIDTH-1:0]             input_data,
  output logic                              overflow,
  output logic                              negative,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
  output logic [4*MAX_DIGITS-1:0]           digits_out
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int IW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int AW = DATA_WIDTH + 4;
  localparam logic [AW-1:0] MAX_POS = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CONVERT, S_DONE} state_t;
  state_t state_q, state_d;

  logic                           key_pulse;
  logic [7:0]                     key_code;
  logic [3:0]                     key_val;
  logic                           is_digit, is_bksp, is_sign;
  logic                           hex_q, neg_q, sticky_q, ovf_q;
  logic [MAX_DIGITS-1:0][3:0]     dig_q;
  logic [CW-1:0]                  cnt_q, left_q;
  logic [IW-1:0]                  idx_q;
  logic [AW-1:0]                  acc_q, acc_nx;
  logic [AW+3:0]                  prod, radix_w;
  logic                           sticky_nx, fin_ovf;
  logic [DATA_WIDTH-1:0]          data_q, mag, fin_data;

  keypad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk       (clk),
    .rst       (rst),
    .key_coord (key_coord),
    .key_pulse (key_pulse),
    .key_code  (key_code)
  );

  // Keypad legend in hex terms: '*' reads as E and '#' as F.
  function automatic logic [3:0] key_value(input logic [7:0] code);
    logic [1:0] r, c;
    r = '0;
    c = '0;
    for (int i = 0; i < 4; i++) begin
      if (code[4+i]) r = 2'(i);
      if (code[i])   c = 2'(i);
    end
    case ({r, c})
      4'h0: key_value = 4'h1;  4'h1: key_value = 4'h2;  4'h2: key_value = 4'h3;  4'h3: key_value = 4'hA;
      4'h4: key_value = 4'h4;  4'h5: key_value = 4'h5;  4'h6: key_value = 4'h6;  4'h7: key_value = 4'hB;
      4'h8: key_value = 4'h7;  4'h9: key_value = 4'h8;  4'hA: key_value = 4'h9;  4'hB: key_value = 4'hC;
      4'hC: key_value = 4'hE;  4'hD: key_value = 4'h0;  4'hE: key_value = 4'hF;  default: key_value = 4'hD;
    endcase
  endfunction

  always_comb begin
    key_val  = key_value(key_code);
    is_digit = hex_q || (key_val <= 4'h9);
    is_bksp  = !hex_q && (key_val == 4'hA);
    is_sign  = !hex_q && (key_val == 4'hB);
  end

  // One conversion step, plus the range check applied on the final step.
  always_comb begin
    radix_w   = hex_q ? (AW+4)'(16) : (AW+4)'(10);
    prod      = {4'h0, acc_q} * radix_w + (AW+4)'(dig_q[idx_q]);
    acc_nx    = prod[AW-1:0];
    sticky_nx = sticky_q | (|prod[AW+3:AW]);
    fin_ovf   = sticky_nx | (hex_q ? (|acc_nx[AW-1:DATA_WIDTH]) : (acc_nx > MAX_POS));
    mag       = acc_nx[DATA_WIDTH-1:0];
    fin_data  = fin_ovf ? '0 : ((neg_q && !hex_q) ? -mag : mag);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (input_enable) state_d = S_ENTRY;
      S_ENTRY: begin
        if (!input_enable)  state_d = S_IDLE;
        else if (clear_btn) state_d = S_ENTRY;
        else if (enter_btn) state_d = S_CONVERT;
      end
      S_CONVERT: if (left_q == CW'(1)) state_d = S_DONE;
      S_DONE:    if (data_ack) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q    <= 1'b0;
      neg_q    <= 1'b0;
      dig_q    <= '0;
      cnt_q    <= '0;
      left_q   <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (input_enable) begin
          hex_q <= hex_mode;
          dig_q <= '0;
          cnt_q <= '0;
          neg_q <= 1'b0;
        end
        S_ENTRY: begin
          if (!input_enable || clear_btn) begin
            dig_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
          end else if (enter_btn) begin
            // An empty buffer still takes one CONVERT cycle and yields zero.
            left_q   <= (cnt_q == '0) ? CW'(1) : cnt_q;
            idx_q    <= (cnt_q == '0) ? '0 : IW'(cnt_q - CW'(1));
            acc_q    <= '0;
            sticky_q <= 1'b0;
          end else if (key_pulse) begin
            if (is_digit) begin
              if (cnt_q != CW'(MAX_DIGITS)) begin
                dig_q <= {dig_q[MAX_DIGITS-2:0], key_val};
                cnt_q <= cnt_q + CW'(1);
              end
            end else if (is_bksp) begin
              if (cnt_q != '0) begin
                dig_q <= {4'h0, dig_q[MAX_DIGITS-1:1]};
                cnt_q <= cnt_q - CW'(1);
              end
            end else if (is_sign) begin
              neg_q <= !neg_q;
            end
          end
        end
        S_CONVERT: begin
          acc_q    <= acc_nx;
          sticky_q <= sticky_nx;
          idx_q    <= idx_q - IW'(1);
          left_q   <= left_q - CW'(1);
          if (left_q == CW'(1)) begin
            data_q <= fin_data;
            ovf_q  <= fin_ovf;
          end
        end
        S_DONE: if (data_ack) begin
          ovf_q <= 1'b0;
          dig_q <= '0;
          cnt_q <= '0;
          neg_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cpu_pause   = (state_q == S_ENTRY) || (state_q == S_CONVERT);
  assign data_valid  = (state_q == S_DONE);
  assign input_data  = data_q;
  assign overflow    = ovf_q;
  assign negative    = neg_q;
  assign digit_count = cnt_q;
  assign digits_out  = dig_q;
endmodule

// File: tb/tb_keypad_entry_unit.sv
// Bench for keypad_entry_unit: an 8-digit and a 10-digit instance share stimulus; results are
// checked against per-instance scoreboards of expected value, overflow and latency.

module tb_keypad_entry_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  key_coord = 8'h00;
  logic        input_enable = 1'b0, hex_mode = 1'b0, enter_btn = 1'b0, clear_btn = 1'b0, data_ack = 1'b0;

  logic        a_pause, a_valid, a_ovf, a_neg, b_pause, b_valid, b_ovf, b_neg;
  logic [31:0] a_data, b_data, a_digits;
  logic [39:0] b_digits;
  logic [3:0]  a_cnt, b_cnt;

  typedef struct { logic [31:0] data; logic ovf; int lat; } exp_t;
  exp_t qa[$], qb[$];
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  keypad_entry_unit #(.DATA_WIDTH(32), .MAX_DIGITS(8), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .key_coord(key_coord), .input_enable(input_enable), .hex_mode(hex_mode),
    .enter_btn(enter_btn), .clear_btn(clear_btn), .data_ack(data_ack), .cpu_pause(a_pause),
    .data_valid(a_valid), .input_data(a_data), .overflow(a_ovf), .negative(a_neg),
    .digit_count(a_cnt), .digits_out(a_digits));

  keypad_entry_unit #(.DATA_WIDTH(32), .MAX_DIGITS(10), .DEBOUNCE_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .key_coord(key_coord), .input_enable(input_enable), .hex_mode(hex_mode),
    .enter_btn(enter_btn), .clear_btn(clear_btn), .data_ack(data_ack), .cpu_pause(b_pause),
    .data_valid(b_valid), .input_data(b_data), .overflow(b_ovf), .negative(b_neg),
    .digit_count(b_cnt), .digits_out(b_digits));

  // Physical position of each legend value: {row one-hot, col one-hot}.
  function automatic logic [7:0] coord_of(input logic [3:0] s);
    case (s)
      4'h1: coord_of = 8'h11;  4'h2: coord_of = 8'h12;  4'h3: coord_of = 8'h14;  4'hA: coord_of = 8'h18;
      4'h4: coord_of = 8'h21;  4'h5: coord_of = 8'h22;  4'h6: coord_of = 8'h24;  4'hB: coord_of = 8'h28;
      4'h7: coord_of = 8'h41;  4'h8: coord_of = 8'h42;  4'h9: coord_of = 8'h44;  4'hC: coord_of = 8'h48;
      4'hE: coord_of = 8'h81;  4'h0: coord_of = 8'h82;  4'hF: coord_of = 8'h84;  default: coord_of = 8'h88;
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] s);
    key_coord = coord_of(s);
    cycles(6);
    key_coord = 8'h00;
    cycles(6);
  endtask

  task automatic start_entry(input logic hex);
    hex_mode     = hex;
    input_enable = 1'b1;
    cycles(2);
  endtask

  // Pulse enter, then pop each instance's expectation when its data_valid rises, then acknowledge.
  task automatic convert_and_score();
    bit ga = 0, gb = 0;
    exp_t e;
    enter_btn = 1'b1;
    for (int k = 1; k <= 60 && !(ga && gb); k++) begin
      @(negedge clk);
      if (k == 1) begin
        enter_btn    = 1'b0;
        input_enable = 1'b0;
      end
      if (!ga && a_valid) begin
        ga = 1;
        n_checks++;
        if (qa.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a: unexpected result %h", a_data);
        end else begin
          e = qa.pop_front();
          if (a_data !== e.data || a_ovf !== e.ovf || k != e.lat) begin
            n_fail++;
            $display("FAIL result_a: got data=%h ovf=%b lat=%0d, expected data=%h ovf=%b lat=%0d",
                     a_data, a_ovf, k, e.data, e.ovf, e.lat);
          end
        end
      end
      if (!gb && b_valid) begin
        gb = 1;
        n_checks++;
        if (qb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_b: unexpected result %h", b_data);
        end else begin
          e = qb.pop_front();
          if (b_data !== e.data || b_ovf !== e.ovf || k != e.lat) begin
            n_fail++;
            $display("FAIL result_b: got data=%h ovf=%b lat=%0d, expected data=%h ovf=%b lat=%0d",
                     b_data, b_ovf, k, e.data, e.ovf, e.lat);
          end
        end
      end
    end
    if (!ga || !gb) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: got a=%b b=%b, expected both 1", ga, gb);
    end
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    n_checks++;
    if ({a_valid, b_valid, a_ovf, b_ovf, a_neg, a_pause} !== 6'b0 || a_cnt !== 4'd0 || b_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL ack_clear: got valid=%b%b ovf=%b%b neg=%b pause=%b cnt=%0d/%0d, expected all 0",
               a_valid, b_valid, a_ovf, b_ovf, a_neg, a_pause, a_cnt, b_cnt);
    end
  endtask

  task automatic test_reset();
    cycles(3);
    n_checks++;
    if ({a_pause, a_valid, a_ovf, a_neg, b_pause, b_valid} !== 6'b0 || a_data !== 32'd0 ||
        a_cnt !== 4'd0 || a_digits !== 32'd0 || b_digits !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_state: got pause=%b valid=%b data=%h cnt=%0d digits=%h, expected zeros",
               a_pause, a_valid, a_data, a_cnt, a_digits);
    end
    rst = 1'b0;
    cycles(6);
    n_checks++;
    if (a_pause !== 1'b0 || a_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got pause=%b cnt=%0d, expected 0 0", a_pause, a_cnt);
    end
  endtask

  task automatic test_decimal_basic();
    start_entry(1'b0);
    n_checks++;
    if (a_pause !== 1'b1 || b_pause !== 1'b1) begin
      n_fail++;
      $display("FAIL entry_pause: got %b %b, expected 1 1", a_pause, b_pause);
    end
    press(4'h1); press(4'h2); press(4'h3);
    n_checks++;
    if (a_cnt !== 4'd3 || a_digits !== 32'h0000_0123) begin
      n_fail++;
      $display("FAIL dec_buffer: got cnt=%0d digits=%h, expected 3 00000123", a_cnt, a_digits);
    end
    qa.push_back('{32'd123, 1'b0, 4});
    qb.push_back('{32'd123, 1'b0, 4});
    convert_and_score();
    n_checks++;
    if (a_data !== 32'd123) begin
      n_fail++;
      $display("FAIL data_hold: got %0d, expected 123", a_data);
    end
  endtask

  task automatic test_sign_backspace();
    start_entry(1'b0);
    press(4'h4); press(4'h5); press(4'hB); press(4'h6);
    n_checks++;
    if (a_cnt !== 4'd3 || a_neg !== 1'b1) begin
      n_fail++;
      $display("FAIL sign_count: got cnt=%0d neg=%b, expected 3 1", a_cnt, a_neg);
    end
    press(4'hA);
    n_checks++;
    if (a_cnt !== 4'd2 || b_cnt !== 4'd2 || a_digits !== 32'h0000_0045) begin
      n_fail++;
      $display("FAIL backspace: got cnt=%0d digits=%h, expected 2 00000045", a_cnt, a_digits);
    end
    qa.push_back('{32'hFFFF_FFD3, 1'b0, 3});
    qb.push_back('{32'hFFFF_FFD3, 1'b0, 3});
    convert_and_score();
  endtask

  task automatic test_empty_enter();
    start_entry(1'b0);
    qa.push_back('{32'd0, 1'b0, 2});
    qb.push_back('{32'd0, 1'b0, 2});
    convert_and_score();
  endtask

  task automatic test_hex();
    logic [3:0] seq [9] = '{4'hD, 4'hE, 4'hA, 4'hD, 4'hB, 4'hE, 4'hE, 4'hF, 4'h1};
    start_entry(1'b1);
    for (int i = 0; i < 9; i++) press(seq[i]);
    n_checks++;
    if (a_cnt !== 4'd8 || b_cnt !== 4'd9 || a_digits !== 32'hDEAD_BEEF || a_neg !== 1'b0) begin
      n_fail++;
      $display("FAIL hex_buffer: got cnt=%0d/%0d digits=%h neg=%b, expected 8/9 deadbeef 0",
               a_cnt, b_cnt, a_digits, a_neg);
    end
    qa.push_back('{32'hDEAD_BEEF, 1'b0, 9});
    qb.push_back('{32'd0, 1'b1, 10});
    convert_and_score();
  endtask

  task automatic test_dec_range();
    logic [3:0] big [10] = '{4'h4, 4'h2, 4'h9, 4'h4, 4'h9, 4'h6, 4'h7, 4'h2, 4'h9, 4'h5};
    logic [3:0] top [10] = '{4'h2, 4'h1, 4'h4, 4'h7, 4'h4, 4'h8, 4'h3, 4'h6, 4'h4, 4'h7};
    start_entry(1'b0);
    for (int i = 0; i < 10; i++) press(big[i]);
    qa.push_back('{32'd42949672, 1'b0, 9});
    qb.push_back('{32'd0, 1'b1, 11});
    convert_and_score();
    start_entry(1'b0);
    for (int i = 0; i < 10; i++) press(top[i]);
    qa.push_back('{32'd21474836, 1'b0, 9});
    qb.push_back('{32'h7FFF_FFFF, 1'b0, 11});
    convert_and_score();
  endtask

  task automatic test_bounce();
    start_entry(1'b0);
    for (int i = 0; i < 5; i++) begin
      key_coord = coord_of(4'h7); cycles(2);
      key_coord = 8'h00;          cycles(2);
    end
    key_coord = coord_of(4'h7); cycles(4);
    key_coord = 8'h00;          cycles(6);
    n_checks++;
    if (a_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL bounce_one: got cnt=%0d, expected 1", a_cnt);
    end
    key_coord = coord_of(4'h7); cycles(100);
    key_coord = 8'h00;          cycles(6);
    n_checks++;
    if (a_cnt !== 4'd2 || a_digits !== 32'h0000_0077) begin
      n_fail++;
      $display("FAIL long_hold: got cnt=%0d digits=%h, expected 2 00000077", a_cnt, a_digits);
    end
  endtask

  task automatic test_clear_enter();
    clear_btn = 1'b1;
    enter_btn = 1'b1;
    @(negedge clk);
    clear_btn = 1'b0;
    enter_btn = 1'b0;
    cycles(4);
    n_checks++;
    if (a_cnt !== 4'd0 || a_pause !== 1'b1 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_over_enter: got cnt=%0d pause=%b valid=%b, expected 0 1 0", a_cnt, a_pause, a_valid);
    end
  endtask

  task automatic test_abort();
    press(4'h5); press(4'h5);
    input_enable = 1'b0;
    cycles(2);
    n_checks++;
    if (a_pause !== 1'b0 || a_cnt !== 4'd0 || b_cnt !== 4'd0 || a_digits !== 32'd0) begin
      n_fail++;
      $display("FAIL abort: got pause=%b cnt=%0d digits=%h, expected 0 0 0", a_pause, a_cnt, a_digits);
    end
  endtask

  task automatic test_reset_in_convert();
    start_entry(1'b0);
    press(4'h9); press(4'h9); press(4'h9);
    enter_btn = 1'b1;
    @(negedge clk);
    enter_btn = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_pause, a_valid, a_ovf, a_neg, b_pause, b_valid} !== 6'b0 || a_data !== 32'd0 ||
        b_data !== 32'd0 || a_cnt !== 4'd0 || a_digits !== 32'd0) begin
      n_fail++;
      $display("FAIL async_reset: got pause=%b data=%h/%h cnt=%0d digits=%h, expected zeros",
               a_pause, a_data, b_data, a_cnt, a_digits);
    end
    input_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
  endtask

  initial begin
    test_reset();
    test_decimal_basic();
    test_sign_backspace();
    test_empty_enter();
    test_hex();
    test_dec_range();
    test_bounce();
    test_clear_enter();
    test_abort();
    test_reset_in_convert();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
